// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in, LSB first; result + carry-out presented with a done pulse WIDTH cycles after start.
// No backpressure: start is only sampled in IDLE and is dropped (not queued) while busy or done.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shr_q, shr_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full adder cell: two half adders, carries merged by an OR.
  logic s0, c0, s1, c1, carry_nxt;
  half_adder u_ha0 (.a(sha_q[0]), .b(shb_q[0]), .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0),       .b(carry_q),  .s(s1), .c(c1));
  assign carry_nxt = c0 | c1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shr_q   <= shr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shr_d   = shr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = A;
          shb_d   = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        shr_d   = {s1, shr_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {s1, shr_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
endmodule
